// File: rtl/ascii_load_buffer.sv
// ascii_load_buffer: buffers an ioctl "Load Ascii" stream, normalises line
// endings and hands bytes to the serial receive path one at a time.
// Delivery is paced: after each acked byte there is an idle gap. The gap is
// longer after a CR so BASIC or the monitor has time to process the line.
module ascii_load_buffer #(
    parameter int          AW       = 9,
    parameter logic [7:0]  INDEX    = 8'd1,
    parameter logic [23:0] CHAR_GAP = 24'd4800,
    parameter logic [23:0] LINE_GAP = 24'd960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ioctl_download,
    input  logic       ioctl_wr,
    input  logic [7:0] ioctl_index,
    input  logic [7:0] ioctl_dout,
    output logic       ioctl_wait,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       busy,
    output logic       overflow
);
    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
    // Two slots of headroom absorb the one write hps_io may issue after wait rises.
    localparam logic [AW:0] WAIT_CNT = FULL_CNT - (AW+1)'(2);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_GAP     = 2'd2;

    logic [7:0]    mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          last_cr_q, last_cr_d;
    logic          dl_q;
    logic          wait_q, wait_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic [1:0]    state_q, state_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    rx_data_q;
    logic [23:0]   gap_q, gap_d;

    logic       wr_acc, dl_rise, dl_mine, last_cr_base;
    logic       store, push, pop, load, full;
    logic [7:0] store_byte;

    assign wr_acc  = ioctl_download & ioctl_wr & (ioctl_index == INDEX);
    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_mine = ioctl_download & (ioctl_index == INDEX);
    assign full    = (count_q == FULL_CNT);

    // Line-ending filter: CRLF -> CR, lone LF -> CR, NUL and ^Z dropped.
    always_comb begin
        last_cr_base = dl_rise ? 1'b0 : last_cr_q;
        last_cr_d    = last_cr_base;
        store        = 1'b0;
        store_byte   = ioctl_dout;
        if (wr_acc) begin
            case (ioctl_dout)
                8'h0D: begin
                    store     = 1'b1;
                    last_cr_d = 1'b1;
                end
                8'h0A: begin
                    last_cr_d = 1'b0;
                    if (!last_cr_base) begin
                        store      = 1'b1;
                        store_byte = 8'h0D;
                    end
                end
                8'h00, 8'h1A: begin
                    store = 1'b0;
                end
                default: begin
                    store     = 1'b1;
                    last_cr_d = 1'b0;
                end
            endcase
        end
    end

    // Output handshake and pacing FSM.
    always_comb begin
        state_d    = state_q;
        rx_valid_d = rx_valid_q;
        gap_d      = gap_q;
        pop        = 1'b0;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    load       = 1'b1;
                    rx_valid_d = 1'b1;
                    state_d    = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (rx_ack) begin
                    pop        = 1'b1;
                    rx_valid_d = 1'b0;
                    gap_d      = (rx_data_q == 8'h0D) ? LINE_GAP : CHAR_GAP;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == 24'd0) state_d = ST_IDLE;
                else                gap_d   = gap_q - 24'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO bookkeeping, backpressure and status flags.
    always_comb begin
        push       = store & ~full;
        overflow_d = overflow_q | (store & full);
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        wait_d     = (count_d >= WAIT_CNT);
        busy_d     = dl_mine | (count_d != '0) | (state_d != ST_IDLE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_cr_q  <= 1'b0;
            dl_q       <= 1'b0;
            wait_q     <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            rx_valid_q <= 1'b0;
            gap_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_cr_q  <= last_cr_d;
            dl_q       <= ioctl_download;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            rx_valid_q <= rx_valid_d;
            gap_q      <= gap_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= store_byte;
    end

    // Registered read of the FIFO head into the presented byte.
    always_ff @(posedge clk) begin
        if (reset)     rx_data_q <= 8'h00;
        else if (load) rx_data_q <= mem[rd_ptr_q];
    end

    assign ioctl_wait = wait_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_ascii_load_buffer.sv
// Directed testbench for ascii_load_buffer (AW=4, CHAR_GAP=4, LINE_GAP=20).
module tb_ascii_load_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic       ioctl_download;
    logic       ioctl_wr;
    logic [7:0] ioctl_index;
    logic [7:0] ioctl_dout;
    logic       ioctl_wait;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    ascii_load_buffer #(
        .AW(4), .INDEX(8'd1), .CHAR_GAP(24'd4), .LINE_GAP(24'd20)
    ) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        tick;
        ioctl_wr   = 1'b0;
    endtask

    // Wait (bounded) for rx_valid, return byte and idle cycles waited, then ack for one cycle.
    task automatic get_byte(input string tag, output logic [7:0] d, output int waited);
        waited = 0;
        d      = 8'h00;
        while (!rx_valid && waited < 200) begin
            tick;
            waited++;
        end
        if (!rx_valid) begin
            chk({tag, "_timeout"}, 32'(rx_valid), 32'd1);
        end else begin
            d      = rx_data;
            rx_ack = 1'b1;
            tick;
            rx_ack = 1'b0;
        end
    endtask

    task automatic no_more(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= rx_valid;
            tick;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    logic [7:0] t1_in  [12] = '{8'h31, 8'h30, 8'h20, 8'h50, 8'h52, 8'h49,
                                8'h4E, 8'h54, 8'h20, 8'h31, 8'h0D, 8'h0A};
    logic [7:0] t1_exp [11] = '{8'h31, 8'h30, 8'h20, 8'h50, 8'h52, 8'h49,
                                8'h4E, 8'h54, 8'h20, 8'h31, 8'h0D};
    logic [7:0] t2_in  [9]  = '{8'h41, 8'h0A, 8'h42, 8'h0D, 8'h0A, 8'h0A, 8'h00, 8'h1A, 8'h43};
    logic [7:0] t2_exp [6]  = '{8'h41, 8'h0D, 8'h42, 8'h0D, 8'h0D, 8'h43};
    int         t2_gap [6]  = '{0, 6, 22, 6, 22, 22};

    initial begin
        logic [7:0] d;
        int         w, n, wait_at;
        logic       seen_v, seen_b;

        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_index = 8'd1; ioctl_dout = 8'h00; rx_ack = 1'b0;
        repeat (3) tick;
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick;

        // 1: "10 PRINT 1\r\n" with pacing
        ioctl_download = 1'b1;
        for (int i = 0; i < 12; i++) wr(t1_in[i]);
        ioctl_download = 1'b0;
        for (int i = 0; i < 11; i++) begin
            get_byte($sformatf("t1_get%0d", i), d, w);
            chk($sformatf("t1_data%0d", i), 32'(d), 32'(t1_exp[i]));
            if (i > 0) chk($sformatf("t1_gap%0d", i), 32'(w), 32'd6);
        end
        n = 0;
        while (busy && n < 100) begin tick; n++; end
        chk("t1_busy_after_cr", 32'(n), 32'd21);
        no_more("t1_no_extra");

        // 2: line-ending normalisation and gap after CR
        ioctl_download = 1'b1;
        for (int i = 0; i < 9; i++) wr(t2_in[i]);
        ioctl_download = 1'b0;
        for (int i = 0; i < 6; i++) begin
            get_byte($sformatf("t2_get%0d", i), d, w);
            chk($sformatf("t2_data%0d", i), 32'(d), 32'(t2_exp[i]));
            if (i > 0) chk($sformatf("t2_gap%0d", i), 32'(w), 32'(t2_gap[i]));
        end
        no_more("t2_no_extra");

        // 3a: writer honouring ioctl_wait
        ioctl_download = 1'b1;
        n = 0; wait_at = -1;
        for (int k = 0; k < 20; k++) begin
            if (ioctl_wait) begin
                if (wait_at < 0) wait_at = n;
                tick;
            end else begin
                wr(8'(8'h60 + n));
                n++;
            end
        end
        ioctl_download = 1'b0;
        chk("t3a_wait_at", 32'(wait_at), 32'd14);
        chk("t3a_written", 32'(n), 32'd14);
        chk("t3a_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 14; i++) begin
            get_byte($sformatf("t3a_get%0d", i), d, w);
            chk($sformatf("t3a_data%0d", i), 32'(d), 32'(8'h60 + i));
        end
        no_more("t3a_no_extra");

        // 3b: writer ignoring ioctl_wait
        ioctl_download = 1'b1;
        for (int k = 0; k < 20; k++) wr(8'(8'h80 + k));
        ioctl_download = 1'b0;
        chk("t3b_overflow", 32'(overflow), 32'd1);
        chk("t3b_wait", 32'(ioctl_wait), 32'd1);
        for (int i = 0; i < 16; i++) begin
            get_byte($sformatf("t3b_get%0d", i), d, w);
            chk($sformatf("t3b_data%0d", i), 32'(d), 32'(8'h80 + i));
        end
        no_more("t3b_no_17th");
        chk("t3b_wait_drained", 32'(ioctl_wait), 32'd0);

        // 4: foreign index ignored
        ioctl_index = 8'd2; ioctl_download = 1'b1;
        seen_v = 1'b0; seen_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wr(8'(8'h30 + k));
            seen_v |= rx_valid; seen_b |= busy;
        end
        ioctl_download = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick;
            seen_v |= rx_valid; seen_b |= busy;
        end
        chk("t4_rx_valid_seen", 32'(seen_v), 32'd0);
        chk("t4_busy_seen", 32'(seen_b), 32'd0);
        ioctl_index = 8'd1;

        // 5: pop and write in the same cycle at count 1
        ioctl_download = 1'b1;
        wr(8'h51);
        n = 0;
        while (!rx_valid && n < 50) begin tick; n++; end
        chk("t5_first", 32'(rx_data), 32'h51);
        rx_ack = 1'b1; ioctl_wr = 1'b1; ioctl_dout = 8'h52;
        tick;
        rx_ack = 1'b0; ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        get_byte("t5_get", d, w);
        chk("t5_second", 32'(d), 32'h52);
        chk("t5_gap", 32'(w), 32'd6);
        no_more("t5_no_dup");

        // 6: reset mid-operation
        ioctl_download = 1'b1;
        for (int k = 0; k < 20; k++) wr(8'(8'h61 + k));
        ioctl_download = 1'b0;
        get_byte("t6_get_pre", d, w);
        tick; tick;
        chk("t6_pre_overflow", 32'(overflow), 32'd1);
        chk("t6_pre_wait", 32'(ioctl_wait), 32'd1);
        reset = 1'b1;
        tick;
        chk("t6_rx_valid", 32'(rx_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_wait", 32'(ioctl_wait), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick;
        ioctl_download = 1'b1;
        wr(8'h41); wr(8'h42);
        ioctl_download = 1'b0;
        get_byte("t6_get0", d, w);
        chk("t6_data0", 32'(d), 32'h41);
        get_byte("t6_get1", d, w);
        chk("t6_data1", 32'(d), 32'h42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
